// File: rtl/vector_capture_pkg.sv
// Shared types and helpers for the vector_capture trace recorder.
package vector_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } vc_state_t;

    function automatic int vc_word_w(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

endpackage

// File: rtl/vector_capture_if.sv
// Capture control, DUT-vector taps and drain port of vector_capture.
interface vector_capture_if
    import vector_capture_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int DEPTH = 16
);
    localparam int WW = vc_word_w(IN_W, OUT_W);
    localparam int CW = $clog2(DEPTH + 1);

    logic             start;
    logic             stop;
    logic [IN_W-1:0]  in_vec;
    logic [OUT_W-1:0] out_vec;
    logic             rd_valid;
    logic             rd_ready;
    logic [WW-1:0]    rd_data;
    logic [CW-1:0]    count;
    logic             busy;
    logic             full;

    modport master (
        output start, stop, in_vec, out_vec, rd_ready,
        input  rd_valid, rd_data, count, busy, full
    );

    modport slave (
        input  start, stop, in_vec, out_vec, rd_ready,
        output rd_valid, rd_data, count, busy, full
    );

endinterface

// File: rtl/vector_capture_buffer_ram.sv
// Simple dual-port capture storage: synchronous write, registered read, no reset on storage.
module vc_buffer_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Storage write port and registered read port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/vector_capture.sv
// Trace recorder: captures {in_vec,out_vec} per clock, then drains FWFT over valid/ready.
// Optional build macro VECTOR_CAPTURE_CHANGE_ONLY_EN stores only words that differ from the previous one.
module vector_capture
    import vector_capture_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    vector_capture_if.slave   vc
);

    localparam int WW = vc_word_w(IN_W, OUT_W);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    vc_state_t     state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic [WW-1:0] rd_data_q, rd_data_d;
    logic          busy_q;
    logic          full_q;
    logic [WW-1:0] word_s;
    logic [WW-1:0] ram_q;
    logic          keep_s;
    logic          wr_en_s;
    logic          xfer_s;

    assign word_s = {vc.in_vec, vc.out_vec};
    assign xfer_s = rd_valid_q && vc.rd_ready;

`ifdef VECTOR_CAPTURE_CHANGE_ONLY_EN
    logic [WW-1:0] last_q;

    // Remember the most recently stored word for change detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= '0;
        end else if (wr_en_s) begin
            last_q <= word_s;
        end else begin
            last_q <= last_q;
        end
    end

    assign keep_s = (count_q == CW'(0)) || (word_s != last_q);
`else
    assign keep_s = 1'b1;
`endif

    // rd_ptr names the next word to load into the output register, so the
    // RAM is addressed with its next value to have that word ready a cycle early.
    vc_buffer_ram #(
        .DEPTH (DEPTH),
        .W     (WW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (word_s),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_q)
    );

    // Next-state, pointer, count and output-register decode.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        wr_en_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (vc.start) begin
                    state_d  = CAPTURE;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                if (vc.stop) begin
                    state_d = (count_q != CW'(0)) ? DRAIN : IDLE;
                end else if (keep_s) begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + CW'(1);
                    if (count_q == CW'(DEPTH - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = CAPTURE;
                    end
                end else begin
                    state_d = CAPTURE;
                end
            end
            DRAIN: begin
                if (xfer_s) begin
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d    = IDLE;
                        rd_valid_d = 1'b0;
                    end else begin
                        rd_data_d = ram_q;
                        rd_ptr_d  = rd_ptr_q + AW'(1);
                    end
                end else if (!rd_valid_q) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = ram_q;
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                end else begin
                    rd_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, count and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= (state_d != IDLE);
            full_q     <= (count_d == CW'(DEPTH));
        end
    end

    assign vc.rd_valid = rd_valid_q;
    assign vc.rd_data  = rd_data_q;
    assign vc.count    = count_q;
    assign vc.busy     = busy_q;
    assign vc.full     = full_q;

endmodule
